// File: rtl/imm_pkg.sv
// imm_pkg: shared definitions for the immediate decode stage.
//   - RV32I/RV64I major opcode constants
//   - fmt_e: format code reported on fmt_o
//   - skid_state_e: occupancy of the output/skid register pair
//   - xlen_legal(): elaboration-time check of the datapath width
package imm_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    // Encoding equals the number of valid entries held.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// imm_decode_stage_if: upstream and downstream handshake bundle of the
// immediate decode stage.
//   in_valid_i/in_ready_o/instr_i/pc_i   : upstream (fetch) side
//   out_valid_o/out_ready_i/imm_o/fmt_o/
//   instr_o/pc_o[/target_o]              : downstream (execute) side
//   target_o exists only when IMM_TARGET_EN is defined.
// Modports: master = surrounding pipeline, slave = the decode stage.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holding valid=1 keeps its payload unchanged until
// the transfer; ready may be asserted independently of valid.
interface imm_decode_stage_if #(parameter int XLEN = 32) ();
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [XLEN-1:0] imm_o;
    logic [2:0]      fmt_o;
    logic [31:0]     instr_o;
    logic [XLEN-1:0] pc_o;
`ifdef IMM_TARGET_EN
    logic [XLEN-1:0] target_o;
`endif

    modport master (
        output in_valid_i, instr_i, pc_i, out_ready_i,
`ifdef IMM_TARGET_EN
        input  target_o,
`endif
        input  in_ready_o, out_valid_o, imm_o, fmt_o, instr_o, pc_o
    );

    modport slave (
        input  in_valid_i, instr_i, pc_i, out_ready_i,
`ifdef IMM_TARGET_EN
        output target_o,
`endif
        output in_ready_o, out_valid_o, imm_o, fmt_o, instr_o, pc_o
    );
endinterface

// File: rtl/imm_extract.sv
// imm_extract: combinational instruction-word to {immediate, format} decoder.
//   instr : 32-bit instruction word
//   imm   : immediate, sign-extended from instr[31] to XLEN (shift amounts
//           are zero-extended when SHAMT_SPLIT=1)
//   fmt   : format code (fmt_e)
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SHAMT_SPLIT = 1
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_shift;
    logic [5:0]        shamt;
    logic signed [31:0] raw;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign is_shift = (SHAMT_SPLIT != 0) && ((funct3 == 3'b001) || (funct3 == 3'b101));
    // Only 64-bit OP-IMM shifts carry a 6-bit shamt; *W shifts stay 5-bit.
    assign shamt    = ((XLEN == 64) && (opcode == OPC_OP_IMM)) ? instr[25:20]
                                                               : {1'b0, instr[24:20]};

    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP_IMM:                     fmt = is_shift ? FMT_SHAMT : FMT_I;
            OPC_OP_IMM_32: if (XLEN == 64)  fmt = is_shift ? FMT_SHAMT : FMT_I;
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = FMT_I;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_NONE;
        endcase
    end

    // Every format is first built as a signed 32-bit value; the signed cast
    // below then extends instr[31] up to XLEN for the RV64 case.
    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I: raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S: raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: raw = {instr[31:12], 12'b0};
            FMT_J: raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
        imm = (fmt == FMT_SHAMT) ? XLEN'(shamt) : XLEN'(raw);
    end

endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decoder with a 2-entry skid buffer.
//   clk, reset : clock; asynchronous active-high reset
//   flush_i    : synchronous flush, drops every held and incoming entry
//   bus        : imm_decode_stage_if slave (upstream + downstream handshake)
//   dbg_state  : current skid occupancy (EMPTY/ONE/TWO)
// Optional: define IMM_TARGET_EN to add target_o = pc + imm for B, J and
// AUIPC (0 otherwise), registered alongside imm_o.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int SHAMT_SPLIT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush_i,
    imm_decode_stage_if.slave     bus,
    output skid_state_e           dbg_state
);

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    // Decode happens on the input side so both registers hold finished results.
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    imm_extract #(.XLEN(XLEN), .SHAMT_SPLIT(SHAMT_SPLIT)) u_extract (
        .instr (bus.instr_i),
        .imm   (dec_imm),
        .fmt   (dec_fmt)
    );

`ifdef IMM_TARGET_EN
    logic [XLEN-1:0] dec_tgt;
    assign dec_tgt = ((dec_fmt == FMT_B) || (dec_fmt == FMT_J) ||
                      ((dec_fmt == FMT_U) && (bus.instr_i[6:0] == OPC_AUIPC)))
                     ? bus.pc_i + dec_imm : '0;
    logic [XLEN-1:0] out_tgt_q, skd_tgt_q;
`endif

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        accept, drain;
    logic        load_out, load_skid, skid_to_out;

    logic [XLEN-1:0] out_imm_q, out_pc_q, skd_imm_q, skd_pc_q;
    logic [31:0]     out_instr_q, skd_instr_q;
    fmt_e            out_fmt_q, skd_fmt_q;

    // Flush masks both handshakes so nothing moves on a flush cycle.
    assign accept = bus.in_valid_i && in_ready_q && !flush_i;
    assign drain  = (state_q != SKID_EMPTY) && bus.out_ready_i && !flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_TWO);
        end
    end

    always_comb begin
        state_d     = state_q;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        if (flush_i) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        state_d  = SKID_ONE;
                        load_out = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (accept && !drain) begin
                        state_d   = SKID_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_out = 1'b1;
                    end else if (drain) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only a drain can happen.
                    if (drain) begin
                        state_d     = SKID_ONE;
                        skid_to_out = 1'b1;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_imm_q   <= '0;
            out_fmt_q   <= FMT_NONE;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            skd_imm_q   <= '0;
            skd_fmt_q   <= FMT_NONE;
            skd_instr_q <= '0;
            skd_pc_q    <= '0;
`ifdef IMM_TARGET_EN
            out_tgt_q   <= '0;
            skd_tgt_q   <= '0;
`endif
        end else begin
            if (load_out) begin
                out_imm_q   <= dec_imm;
                out_fmt_q   <= dec_fmt;
                out_instr_q <= bus.instr_i;
                out_pc_q    <= bus.pc_i;
`ifdef IMM_TARGET_EN
                out_tgt_q   <= dec_tgt;
`endif
            end else if (skid_to_out) begin
                out_imm_q   <= skd_imm_q;
                out_fmt_q   <= skd_fmt_q;
                out_instr_q <= skd_instr_q;
                out_pc_q    <= skd_pc_q;
`ifdef IMM_TARGET_EN
                out_tgt_q   <= skd_tgt_q;
`endif
            end
            if (load_skid) begin
                skd_imm_q   <= dec_imm;
                skd_fmt_q   <= dec_fmt;
                skd_instr_q <= bus.instr_i;
                skd_pc_q    <= bus.pc_i;
`ifdef IMM_TARGET_EN
                skd_tgt_q   <= dec_tgt;
`endif
            end
        end
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = (state_q != SKID_EMPTY);
    assign bus.imm_o       = out_imm_q;
    assign bus.fmt_o       = out_fmt_q;
    assign bus.instr_o     = out_instr_q;
    assign bus.pc_o        = out_pc_q;
`ifdef IMM_TARGET_EN
    assign bus.target_o    = out_tgt_q;
`endif
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
`timescale 1ns/1ps
module tb_imm_decode_stage;
    import imm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic flush64;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32)) b32();
    imm_decode_stage_if #(.XLEN(64)) b64();
    skid_state_e dbg32, dbg64;

    imm_decode_stage #(.XLEN(32), .SHAMT_SPLIT(1)) u_dut32 (
        .clk(clk), .reset(reset), .flush_i(flush), .bus(b32), .dbg_state(dbg32)
    );
    imm_decode_stage #(.XLEN(64), .SHAMT_SPLIT(1)) u_dut64 (
        .clk(clk), .reset(reset), .flush_i(flush64), .bus(b64), .dbg_state(dbg64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];      // instruction words held by the stage, oldest first
    logic [31:0] exp_pc_q[$];

    logic [6:0] opc_tab [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h1b,
                                 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_fmt(input logic [31:0] ins, input int xlen);
        int opc;
        int f3;
        bit sh;
        opc = int'(ins & 32'h7f);
        f3  = int'((ins >> 12) & 32'h7);
        sh  = (f3 == 1) || (f3 == 5);
        case (opc)
            'h13:             return sh ? 6 : 1;
            'h1b:             return (xlen == 64) ? (sh ? 6 : 1) : 0;
            'h03, 'h67, 'h73: return 1;
            'h23:             return 2;
            'h63:             return 3;
            'h37, 'h17:       return 4;
            'h6f:             return 5;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input int xlen);
        longint u;
        longint v;
        u = longint'(ins);
        v = 0;
        case (ref_fmt(ins, xlen))
            1: begin
                v = (u >> 20) & 'hfff;
                if (v >= 2048) v -= 4096;
            end
            2: begin
                v = ((u >> 25) << 5) | ((u >> 7) & 'h1f);
                if (v >= 2048) v -= 4096;
            end
            3: begin
                v = (((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                    (((u >> 25) & 'h3f) << 5) | (((u >> 8) & 'hf) << 1);
                if (v >= 4096) v -= 8192;
            end
            4: begin
                v = u & 64'hfffff000;
                if (v >= 64'sh80000000) v -= 64'sh100000000;
            end
            5: begin
                v = (((u >> 31) & 1) << 20) | (((u >> 12) & 'hff) << 12) |
                    (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3ff) << 1);
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            6: v = (u >> 20) & (((xlen == 64) && ((u & 'h7f) == 'h13)) ? 63 : 31);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'hffffffff;
        return 64'(v);
    endfunction

    function automatic logic [63:0] ref_tgt(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
        int f;
        logic [63:0] t;
        f = ref_fmt(ins, xlen);
        if ((f == 3) || (f == 5) || ((f == 4) && ((ins & 32'h7f) == 32'h17)))
            t = pc + ref_imm(ins, xlen);
        else
            t = '0;
        if (xlen == 32) t = t & 64'hffffffff;
        return t;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom());
        else                           r[6:0] = opc_tab[$urandom_range(0, 9)];
        return r;
    endfunction

    // ---------------- driver tasks (32-bit instance) ----------------
    task automatic sample32();
        logic [31:0] ins;
        logic [31:0] pc;
        @(negedge clk);
        check("out_valid", 64'(b32.out_valid_o), 64'(exp_q.size() > 0));
        check("in_ready",  64'(b32.in_ready_o),  64'(exp_q.size() < 2));
        check("state",     64'(dbg32),           64'(exp_q.size()));
        if (exp_q.size() > 0) begin
            ins = exp_q[0];
            pc  = exp_pc_q[0];
            check("instr", 64'(b32.instr_o), 64'(ins));
            check("pc",    64'(b32.pc_o),    64'(pc));
            check("fmt",   64'(b32.fmt_o),   64'(ref_fmt(ins, 32)));
            check("imm",   64'(b32.imm_o),   ref_imm(ins, 32));
`ifdef IMM_TARGET_EN
            check("target", 64'(b32.target_o), ref_tgt(ins, 64'(pc), 32));
`endif
        end
    endtask

    task automatic drive32(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                           input logic ordy, input logic fl);
        bit acc;
        bit drn;
        b32.in_valid_i  = v;
        b32.instr_i     = ins;
        b32.pc_i        = pc;
        b32.out_ready_i = ordy;
        flush           = fl;
        acc = v && (exp_q.size() < 2) && !fl;
        drn = (exp_q.size() > 0) && ordy && !fl;
        if (fl) begin
            exp_q.delete();
            exp_pc_q.delete();
        end else begin
            if (drn) begin
                void'(exp_q.pop_front());
                void'(exp_pc_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(ins);
                exp_pc_q.push_back(pc);
            end
        end
    endtask

    task automatic step32(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic ordy, input logic fl);
        sample32();
        drive32(v, ins, pc, ordy, fl);
    endtask

    // ---------------- main sequence ----------------
    logic [31:0] w64[$];
    logic [63:0] p64[$];

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        flush64 = 1'b0;
        b32.in_valid_i = 0; b32.instr_i = '0; b32.pc_i = '0; b32.out_ready_i = 0;
        b64.in_valid_i = 0; b64.instr_i = '0; b64.pc_i = '0; b64.out_ready_i = 0;
        #1;
        check("rst_out_valid", 64'(b32.out_valid_o), 64'd0);
        check("rst_in_ready",  64'(b32.in_ready_o),  64'd1);
        check("rst_imm",       64'(b32.imm_o),       64'd0);
        check("rst_fmt",       64'(b32.fmt_o),       64'd0);
        check("rst_instr",     64'(b32.instr_o),     64'd0);
        check("rst_pc",        64'(b32.pc_o),        64'd0);
        check("rst64_valid",   64'(b64.out_valid_o), 64'd0);
        check("rst64_imm",     64'(b64.imm_o),       64'd0);
`ifdef IMM_TARGET_EN
        check("rst_target",    64'(b32.target_o),    64'd0);
`endif
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,-1
        step32(1, 32'hFFF00093, 32'h0, 1, 0);
        sample32();
        check("addi_imm", 64'(b32.imm_o), 64'hFFFFFFFF);
        check("addi_fmt", 64'(b32.fmt_o), 64'd1);
        // beq offset -4 at pc 0x100
        drive32(1, 32'hFE000EE3, 32'h100, 1, 0);
        sample32();
        check("beq_imm", 64'(b32.imm_o), 64'hFFFFFFFC);
        check("beq_fmt", 64'(b32.fmt_o), 64'd3);
`ifdef IMM_TARGET_EN
        check("beq_target", 64'(b32.target_o), 64'hFC);
`endif
        // unknown opcode
        drive32(1, 32'h0000007F, 32'h104, 1, 0);
        sample32();
        check("unk_fmt", 64'(b32.fmt_o), 64'd0);
        check("unk_imm", 64'(b32.imm_o), 64'd0);
        drive32(0, 32'h0, 32'h0, 1, 0);

        // backpressure: three words, third must wait upstream
        step32(1, 32'h00500113, 32'h200, 0, 0);
        step32(1, 32'h00A12023, 32'h204, 0, 0);
        step32(1, 32'h008000EF, 32'h208, 0, 0);
        sample32();
        check("bp_in_ready", 64'(b32.in_ready_o), 64'd0);
        check("bp_hold_instr", 64'(b32.instr_o), 64'h00500113);
        drive32(1, 32'h008000EF, 32'h208, 0, 0);
        sample32();
        check("bp_stable_instr", 64'(b32.instr_o), 64'h00500113);
        check("bp_stable_imm",   64'(b32.imm_o),   64'd5);
        drive32(1, 32'h008000EF, 32'h208, 1, 0);
        repeat (4) step32(0, 32'h0, 32'h0, 1, 0);

        // flush while two entries are held, with a concurrent input
        step32(1, 32'h12345037, 32'h300, 0, 0);
        step32(1, 32'h00001017, 32'h304, 0, 0);
        step32(1, 32'hFE000EE3, 32'h308, 1, 1);
        sample32();
        check("flush_out_valid", 64'(b32.out_valid_o), 64'd0);
        check("flush_in_ready",  64'(b32.in_ready_o),  64'd1);
        drive32(0, 32'h0, 32'h0, 1, 0);
        repeat (3) step32(0, 32'h0, 32'h0, 1, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step32($urandom_range(0, 9) < 7, rand_instr(), $urandom(),
                   $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
        end
        repeat (3) step32(0, 32'h0, 32'h0, 1, 0);

        // reset asserted with two entries held
        step32(1, 32'hFFF00093, 32'h400, 0, 0);
        step32(1, 32'h03F09093, 32'h404, 0, 0);
        sample32();
        b32.in_valid_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(b32.out_valid_o), 64'd0);
        check("mid_rst_ready", 64'(b32.in_ready_o),  64'd1);
        check("mid_rst_imm",   64'(b32.imm_o),       64'd0);
        check("mid_rst_fmt",   64'(b32.fmt_o),       64'd0);
        check("mid_rst_instr", 64'(b32.instr_o),     64'd0);
        check("mid_rst_pc",    64'(b32.pc_o),        64'd0);
        exp_q.delete();
        exp_pc_q.delete();
        @(negedge clk);
        reset = 1'b0;
        drive32(0, 32'h0, 32'h0, 1, 0);
        repeat (2) step32(0, 32'h0, 32'h0, 1, 0);

        // 64-bit instance: streamed words, always drained
        w64.push_back(32'h800000B7);
        w64.push_back(32'h03F09093);
        for (int i = 0; i < 80; i++) w64.push_back(rand_instr());
        for (int i = 0; i < w64.size(); i++) p64.push_back({$urandom(), $urandom()});
        b64.out_ready_i = 1'b1;
        for (int i = 0; i <= w64.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("x64_valid", 64'(b64.out_valid_o), 64'd1);
                check("x64_ready", 64'(b64.in_ready_o),  64'd1);
                check("x64_instr", 64'(b64.instr_o),     64'(w64[i-1]));
                check("x64_pc",    b64.pc_o,             p64[i-1]);
                check("x64_fmt",   64'(b64.fmt_o),       64'(ref_fmt(w64[i-1], 64)));
                check("x64_imm",   b64.imm_o,            ref_imm(w64[i-1], 64));
`ifdef IMM_TARGET_EN
                check("x64_target", b64.target_o,        ref_tgt(w64[i-1], p64[i-1], 64));
`endif
            end
            if (i == 1) begin
                check("lui64_imm", b64.imm_o, 64'hFFFFFFFF80000000);
                check("lui64_fmt", 64'(b64.fmt_o), 64'd4);
            end
            if (i == 2) begin
                check("slli64_imm", b64.imm_o, 64'd63);
                check("slli64_fmt", 64'(b64.fmt_o), 64'd6);
            end
            if (i < w64.size()) begin
                b64.in_valid_i = 1'b1;
                b64.instr_i    = w64[i];
                b64.pc_i       = p64[i];
            end else begin
                b64.in_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        check("x64_drained", 64'(b64.out_valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
